// File: rtl/timestamp_extender.sv
// Extends the short DUT timestamp from the serial stream to a full-width count in the
// recovered DUT timebase, and tracks the minimum transport delay with acquire/track/loss logic.
module timestamp_extender #(
  parameter int COUNT_W     = 32,
  parameter int IN_W        = 8,
  parameter int ACQ_SAMPLES = 16,
  parameter int DECAY_EDGES = 65536,
  parameter int JITTER_TOL  = 4,
  parameter int LOSS_COUNT  = 8
) (
  input  logic               clk_128M,
  input  logic               rst_128M,
  input  logic               gt_clk_edge_128M,
  input  logic [IN_W-1:0]    timestamp_in,
  input  logic               timestamp_valid,
  output logic [COUNT_W-1:0] timestamp_count,
  output logic [COUNT_W-1:0] sample_ts,
  output logic               sample_ts_valid,
  output logic               sample_late,
  output logic [IN_W-1:0]    offset,
  output logic               offset_adjust,
  output logic               locked
);

  localparam int SCNT_W = $clog2(ACQ_SAMPLES + 1);
  localparam int LCNT_W = $clog2(LOSS_COUNT + 1);
  localparam int DCNT_W = $clog2(DECAY_EDGES + 1);

  localparam logic [SCNT_W-1:0] ACQ_LAST   = SCNT_W'(ACQ_SAMPLES - 1);
  localparam logic [LCNT_W-1:0] LOSS_LAST  = LCNT_W'(LOSS_COUNT - 1);
  localparam logic [DCNT_W-1:0] DECAY_LAST = DCNT_W'(DECAY_EDGES - 1);
  localparam logic [IN_W:0]     TOL        = (IN_W + 1)'(JITTER_TOL);
  localparam logic [IN_W-1:0]   OFFSET_MAX = '1;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [COUNT_W-1:0] counter;
  logic [SCNT_W-1:0]  sample_cnt;
  logic [LCNT_W-1:0]  late_cnt;
  logic [DCNT_W-1:0]  decay_cnt;

  logic [IN_W-1:0]    delta;
  logic [IN_W:0]      late_limit;
  logic               is_lower;
  logic               is_late;
  logic               acq_done;
  logic               loss;
  logic               decay_step;

  // Delta is taken against the counter before any same-cycle increment; the late
  // threshold is one bit wider so offset + tolerance never wraps.
  always_comb begin
    delta      = counter[IN_W-1:0] - timestamp_in;
    late_limit = {1'b0, offset} + TOL;
    is_lower   = (delta < offset);
    is_late    = ({1'b0, delta} > late_limit);
    decay_step = (state == TRACK) && gt_clk_edge_128M && (decay_cnt == DECAY_LAST);
    state_next = state;
    acq_done   = 1'b0;
    loss       = 1'b0;
    case (state)
      ACQUIRE: begin
        if (timestamp_valid && (sample_cnt == ACQ_LAST)) begin
          acq_done   = 1'b1;
          state_next = TRACK;
        end
      end
      TRACK: begin
        if (timestamp_valid && is_late && (late_cnt == LOSS_LAST)) begin
          loss       = 1'b1;
          state_next = ACQUIRE;
        end
      end
      default: state_next = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk_128M) begin
    if (rst_128M) state <= ACQUIRE;
    else          state <= state_next;
  end

  assign locked = (state == TRACK);

  always_ff @(posedge clk_128M) begin
    if (rst_128M) begin
      counter         <= '0;
      timestamp_count <= '0;
      sample_ts       <= '0;
      sample_ts_valid <= 1'b0;
      sample_late     <= 1'b0;
      offset          <= OFFSET_MAX;
      offset_adjust   <= 1'b0;
      sample_cnt      <= '0;
      late_cnt        <= '0;
      decay_cnt       <= '0;
    end else begin
      counter         <= counter + {{(COUNT_W-1){1'b0}}, gt_clk_edge_128M};
      timestamp_count <= counter;
      sample_ts_valid <= timestamp_valid;
      sample_late     <= timestamp_valid && (state == TRACK) && is_late;
      offset_adjust   <= timestamp_valid && is_lower;

      if (timestamp_valid)
        sample_ts <= counter - {{(COUNT_W-IN_W){1'b0}}, delta};

      // A lowering sample takes priority over a coincident decay step.
      if (loss)
        offset <= OFFSET_MAX;
      else if (timestamp_valid && is_lower)
        offset <= delta;
      else if (decay_step && (offset != OFFSET_MAX))
        offset <= offset + IN_W'(1);

      if (state != ACQUIRE || acq_done)
        sample_cnt <= '0;
      else if (timestamp_valid)
        sample_cnt <= sample_cnt + SCNT_W'(1);

      if (state != TRACK || loss)
        late_cnt <= '0;
      else if (timestamp_valid)
        late_cnt <= is_late ? late_cnt + LCNT_W'(1) : '0;

      if (state != TRACK || loss)
        decay_cnt <= '0;
      else if (gt_clk_edge_128M)
        decay_cnt <= decay_step ? '0 : decay_cnt + DCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_timestamp_extender.sv
// Directed bench for timestamp_extender: counter, wrap, acquire, decay, loss and reset cases,
// plus a narrow-counter instance so the full counter wrap can be reached in simulation.
module tb_timestamp_extender;

  logic        clk_128M = 1'b0;
  logic        rst_128M;
  logic        gt_clk_edge_128M;
  logic [7:0]  timestamp_in;
  logic        timestamp_valid;
  logic [31:0] timestamp_count;
  logic [31:0] sample_ts;
  logic        sample_ts_valid;
  logic        sample_late;
  logic [7:0]  offset;
  logic        offset_adjust;
  logic        locked;

  logic        edge_s;
  logic [7:0]  ts_in_s;
  logic        valid_s;
  logic [9:0]  count_s;
  logic [9:0]  sample_ts_s;
  logic        sample_valid_s;
  logic        late_s;
  logic [7:0]  offset_s;
  logic        adjust_s;
  logic        locked_s;

  logic [31:0] exp_cnt;
  logic [31:0] pre_cnt;
  int          checks = 0;
  int          errors = 0;

  always #4 clk_128M = ~clk_128M;

  timestamp_extender #(
    .COUNT_W(32), .IN_W(8), .ACQ_SAMPLES(4), .DECAY_EDGES(16), .JITTER_TOL(4), .LOSS_COUNT(3)
  ) dut (
    .clk_128M(clk_128M), .rst_128M(rst_128M), .gt_clk_edge_128M(gt_clk_edge_128M),
    .timestamp_in(timestamp_in), .timestamp_valid(timestamp_valid),
    .timestamp_count(timestamp_count), .sample_ts(sample_ts), .sample_ts_valid(sample_ts_valid),
    .sample_late(sample_late), .offset(offset), .offset_adjust(offset_adjust), .locked(locked)
  );

  timestamp_extender #(
    .COUNT_W(10), .IN_W(8), .ACQ_SAMPLES(4), .DECAY_EDGES(16), .JITTER_TOL(4), .LOSS_COUNT(3)
  ) dut_small (
    .clk_128M(clk_128M), .rst_128M(rst_128M), .gt_clk_edge_128M(edge_s),
    .timestamp_in(ts_in_s), .timestamp_valid(valid_s),
    .timestamp_count(count_s), .sample_ts(sample_ts_s), .sample_ts_valid(sample_valid_s),
    .sample_late(late_s), .offset(offset_s), .offset_adjust(adjust_s), .locked(locked_s)
  );

  task automatic tick();
    @(posedge clk_128M);
    #1;
  endtask

  task automatic drive(input logic e, input logic v, input logic [7:0] ts);
    gt_clk_edge_128M = e;
    timestamp_valid  = v;
    timestamp_in     = ts;
    pre_cnt          = exp_cnt;
    tick();
    if (e) exp_cnt = exp_cnt + 32'd1;
    gt_clk_edge_128M = 1'b0;
    timestamp_valid  = 1'b0;
  endtask

  task automatic sample(input logic e, input logic [7:0] d);
    logic [7:0] low;
    low = exp_cnt[7:0];
    drive(e, 1'b1, low - d);
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_128M = 1'b1;
    gt_clk_edge_128M = 1'b0; timestamp_valid = 1'b0; timestamp_in = 8'h00;
    edge_s = 1'b0; valid_s = 1'b0; ts_in_s = 8'h00;
    tick();
    tick();
    rst_128M = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (timestamp_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %h want %h", timestamp_count, 32'd0); end
    checks++; if (sample_ts !== 32'd0) begin errors++; $display("FAIL rst_sample_ts: got %h want %h", sample_ts, 32'd0); end
    checks++; if (offset !== 8'hFF) begin errors++; $display("FAIL rst_offset: got %h want %h", offset, 8'hFF); end
    checks++; if ({sample_ts_valid, sample_late, offset_adjust, locked} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want %b", {sample_ts_valid, sample_late, offset_adjust, locked}, 4'b0000); end
    edges(10);
    drive(1'b0, 1'b0, 8'h00);
    checks++; if (timestamp_count !== 32'd10) begin errors++; $display("FAIL count10: got %0d want %0d", timestamp_count, 10); end
    checks++; if (offset !== 8'hFF || locked !== 1'b0 || sample_ts_valid !== 1'b0 || offset_adjust !== 1'b0) begin errors++; $display("FAIL idle_state: got off=%h lk=%b v=%b adj=%b want off=ff lk=0 v=0 adj=0", offset, locked, sample_ts_valid, offset_adjust); end
    // counter=10, ts=10-255 -> delta all-ones against offset all-ones
    sample(1'b0, 8'hFF);
    checks++; if (sample_ts_valid !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b want 1", sample_ts_valid); end
    checks++; if (offset_adjust !== 1'b0 || offset !== 8'hFF || sample_late !== 1'b0) begin errors++; $display("FAIL ff_no_adjust: got adj=%b off=%h late=%b want adj=0 off=ff late=0", offset_adjust, offset, sample_late); end
    checks++; if (sample_ts !== 32'hFFFFFF0B) begin errors++; $display("FAIL ff_sample_ts: got %h want %h", sample_ts, 32'hFFFFFF0B); end
  endtask

  task automatic test_wrap();
    do_reset();
    edges(259);
    drive(1'b0, 1'b1, 8'hFE);
    checks++; if (sample_ts_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", sample_ts_valid); end
    checks++; if (sample_ts !== 32'h000000FE) begin errors++; $display("FAIL wrap_sample_ts: got %h want %h", sample_ts, 32'h000000FE); end
    checks++; if (offset !== 8'h05 || offset_adjust !== 1'b1) begin errors++; $display("FAIL wrap_delta: got off=%h adj=%b want off=05 adj=1", offset, offset_adjust); end
    checks++; if (timestamp_count !== 32'h00000103) begin errors++; $display("FAIL wrap_count: got %h want %h", timestamp_count, 32'h103); end
    drive(1'b0, 1'b0, 8'h00);
    checks++; if (sample_ts_valid !== 1'b0 || offset_adjust !== 1'b0) begin errors++; $display("FAIL wrap_strobe_len: got v=%b adj=%b want 0 0", sample_ts_valid, offset_adjust); end
    checks++; if (sample_ts !== 32'h000000FE) begin errors++; $display("FAIL wrap_hold: got %h want %h", sample_ts, 32'hFE); end
  endtask

  task automatic test_small_wrap();
    do_reset();
    edge_s = 1'b1;
    for (int i = 0; i < 1024; i++) tick();
    edge_s = 1'b0;
    checks++; if (count_s !== 10'h3FF) begin errors++; $display("FAIL small_max: got %h want %h", count_s, 10'h3FF); end
    tick();
    checks++; if (count_s !== 10'h000) begin errors++; $display("FAIL small_wrap: got %h want %h", count_s, 10'h000); end
  endtask

  task automatic test_acquire();
    do_reset();
    edges(20);
    sample(1'b0, 8'd7);
    checks++; if (offset !== 8'd7 || offset_adjust !== 1'b1) begin errors++; $display("FAIL acq1: got off=%0d adj=%b want off=7 adj=1", offset, offset_adjust); end
    checks++; if (sample_ts !== 32'd13 || sample_late !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL acq1_ts: got ts=%0d late=%b lk=%b want ts=13 late=0 lk=0", sample_ts, sample_late, locked); end
    sample(1'b0, 8'd5);
    checks++; if (offset !== 8'd5 || offset_adjust !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL acq2: got off=%0d adj=%b lk=%b want 5 1 0", offset, offset_adjust, locked); end
    sample(1'b0, 8'd6);
    checks++; if (offset !== 8'd5 || offset_adjust !== 1'b0 || locked !== 1'b0 || sample_late !== 1'b0) begin errors++; $display("FAIL acq3: got off=%0d adj=%b lk=%b late=%b want 5 0 0 0", offset, offset_adjust, locked, sample_late); end
    sample(1'b0, 8'd9);
    checks++; if (offset !== 8'd5 || offset_adjust !== 1'b0 || sample_late !== 1'b0) begin errors++; $display("FAIL acq4: got off=%0d adj=%b late=%b want 5 0 0", offset, offset_adjust, sample_late); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL acq_lock: got %b want 1", locked); end
  endtask

  task automatic test_decay();
    edges(16);
    checks++; if (offset !== 8'd6) begin errors++; $display("FAIL decay16: got %0d want 6", offset); end
    edges(16);
    checks++; if (offset !== 8'd7) begin errors++; $display("FAIL decay32: got %0d want 7", offset); end
    sample(1'b0, 8'd6);
    checks++; if (offset !== 8'd6 || offset_adjust !== 1'b1 || sample_late !== 1'b0) begin errors++; $display("FAIL decay_lower: got off=%0d adj=%b late=%b want 6 1 0", offset, offset_adjust, sample_late); end
    edges(15);
    checks++; if (offset !== 8'd6) begin errors++; $display("FAIL decay15: got %0d want 6", offset); end
    sample(1'b1, 8'd3);
    checks++; if (offset !== 8'd3 || offset_adjust !== 1'b1) begin errors++; $display("FAIL coincide: got off=%0d adj=%b want 3 1", offset, offset_adjust); end
    checks++; if (sample_ts !== pre_cnt - 32'd3) begin errors++; $display("FAIL coincide_ts: got %h want %h", sample_ts, pre_cnt - 32'd3); end
    edges(15);
    checks++; if (offset !== 8'd3) begin errors++; $display("FAIL post_coincide15: got %0d want 3", offset); end
    edges(1);
    checks++; if (offset !== 8'd4) begin errors++; $display("FAIL post_coincide16: got %0d want 4", offset); end
  endtask

  task automatic test_loss();
    do_reset();
    for (int i = 0; i < 4; i++) sample(1'b0, 8'd5);
    checks++; if (locked !== 1'b1 || offset !== 8'd5) begin errors++; $display("FAIL loss_setup: got lk=%b off=%0d want 1 5", locked, offset); end
    sample(1'b0, 8'd9);
    checks++; if (sample_late !== 1'b0) begin errors++; $display("FAIL late_boundary: got %b want 0", sample_late); end
    sample(1'b0, 8'd10);
    checks++; if (sample_late !== 1'b1 || sample_ts_valid !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL late1: got late=%b v=%b lk=%b want 1 1 1", sample_late, sample_ts_valid, locked); end
    sample(1'b0, 8'd6);
    checks++; if (sample_late !== 1'b0 || locked !== 1'b1 || offset !== 8'd5) begin errors++; $display("FAIL late_clear: got late=%b lk=%b off=%0d want 0 1 5", sample_late, locked, offset); end
    sample(1'b0, 8'd10);
    sample(1'b0, 8'd12);
    checks++; if (sample_late !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL late2of3: got late=%b lk=%b want 1 1", sample_late, locked); end
    sample(1'b0, 8'd11);
    checks++; if (sample_late !== 1'b1 || locked !== 1'b0 || offset !== 8'hFF) begin errors++; $display("FAIL loss: got late=%b lk=%b off=%h want 1 0 ff", sample_late, locked, offset); end
    sample(1'b0, 8'd200);
    checks++; if (sample_late !== 1'b0 || offset !== 8'd200 || offset_adjust !== 1'b1) begin errors++; $display("FAIL reacquire: got late=%b off=%0d adj=%b want 0 200 1", sample_late, offset, offset_adjust); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    edges(5);
    sample(1'b0, 8'd8);
    sample(1'b0, 8'd6);
    rst_128M = 1'b1;
    drive(1'b1, 1'b1, 8'h00);
    rst_128M = 1'b0;
    exp_cnt = 32'd0;
    checks++; if (timestamp_count !== 32'd0 || sample_ts !== 32'd0 || offset !== 8'hFF) begin errors++; $display("FAIL mid_rst_vals: got cnt=%h ts=%h off=%h want 0 0 ff", timestamp_count, sample_ts, offset); end
    checks++; if ({sample_ts_valid, sample_late, offset_adjust, locked} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags: got %b want 0000", {sample_ts_valid, sample_late, offset_adjust, locked}); end
    drive(1'b0, 1'b0, 8'h00);
    checks++; if (timestamp_count !== 32'd0) begin errors++; $display("FAIL mid_rst_counter: got %0d want 0", timestamp_count); end
    edges(7);
    sample(1'b1, 8'd4);
    checks++; if (offset !== 8'd4 || sample_ts !== 32'd3) begin errors++; $display("FAIL simul_edge: got off=%0d ts=%0d want 4 3", offset, sample_ts); end
    drive(1'b0, 1'b0, 8'h00);
    checks++; if (timestamp_count !== 32'd8) begin errors++; $display("FAIL simul_count: got %0d want 8", timestamp_count); end
    sample(1'b0, 8'd4);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL restart2: got %b want 0", locked); end
    sample(1'b0, 8'd4);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL restart3: got %b want 0", locked); end
    sample(1'b0, 8'd4);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL restart4: got %b want 1", locked); end
  endtask

  initial begin
    exp_cnt = 32'd0;
    pre_cnt = 32'd0;
    test_reset();
    test_wrap();
    test_small_wrap();
    test_acquire();
    test_decay();
    test_loss();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
